// File: rtl/bus_mux_reg.sv
// Registered one-hot bus multiplexer with bus keeper, multi-driver conflict tracking
// and select/valid report. Optional registered even parity via BUS_MUX_PARITY_EN.
module bus_mux_reg #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 24,
   parameter int SELW  = 5,
   parameter int CNTW  = 8
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       src_en,
   input  logic                  hold,
   input  logic                  clr_err,
   output logic [WIDTH-1:0]      bus_out,
   output logic [SELW-1:0]       sel_out,
   output logic                  bus_valid,
   output logic                  conflict_flag,
   output logic [CNTW-1:0]       conflict_cnt,
   output logic                  bus_parity
);

   typedef enum logic [1:0] {
      MODE_LOAD = 2'd0,
      MODE_KEEP = 2'd1,
      MODE_HOLD = 2'd2
   } mode_t;

   // Scanning downward leaves the lowest asserted index as the final answer.
   function automatic logic [SELW-1:0] lowest_index(input logic [NSRC-1:0] en);
      logic [SELW-1:0] idx;
      idx = {SELW{1'b0}};
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (en[i]) begin
            idx = SELW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

`ifdef BUS_MUX_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction
`endif

   localparam logic [NSRC-1:0] EN_ONE   = {{(NSRC-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

   logic [NSRC-1:0]  onehot_s;
   logic             any_en_s;
   logic             multi_s;
   logic [SELW-1:0]  sel_s;
   logic [WIDTH-1:0] word_s;
   mode_t            mode_s;

   // Encoder: isolate the lowest enable so conflicts still yield a single winner.
   always_comb begin
      onehot_s = src_en & (~src_en + EN_ONE);
      any_en_s = |src_en;
      multi_s  = |(src_en & (src_en - EN_ONE));
      sel_s    = lowest_index(src_en);
   end

   // AND-OR word select driven by the isolated winner bit.
   always_comb begin
      word_s = {WIDTH{1'b0}};
      for (int i = 0; i < NSRC; i++) begin
         word_s = word_s | (src_data[i*WIDTH +: WIDTH] & {WIDTH{onehot_s[i]}});
      end
   end

   // Per-cycle register mode; hold dominates the enables.
   always_comb begin
      mode_s = MODE_KEEP;
      if (hold) begin
         mode_s = MODE_HOLD;
      end else if (any_en_s) begin
         mode_s = MODE_LOAD;
      end else begin
         mode_s = MODE_KEEP;
      end
   end

   // Bus register, select report and valid flag.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         bus_out   <= {WIDTH{1'b0}};
         sel_out   <= {SELW{1'b0}};
         bus_valid <= 1'b0;
      end else begin
         case (mode_s)
            MODE_LOAD: begin
               bus_out   <= word_s;
               sel_out   <= sel_s;
               bus_valid <= 1'b1;
            end
            MODE_KEEP: begin
               bus_out   <= bus_out;
               sel_out   <= sel_out;
               bus_valid <= 1'b0;
            end
            MODE_HOLD: begin
               bus_out   <= bus_out;
               sel_out   <= sel_out;
               bus_valid <= bus_valid;
            end
            default: begin
               bus_out   <= bus_out;
               sel_out   <= sel_out;
               bus_valid <= 1'b0;
            end
         endcase
      end
   end

   // Conflict tracking runs regardless of hold; clr_err beats a simultaneous conflict.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         conflict_flag <= 1'b0;
         conflict_cnt  <= CNT_ZERO;
      end else if (clr_err) begin
         conflict_flag <= 1'b0;
         conflict_cnt  <= CNT_ZERO;
      end else if (multi_s) begin
         conflict_flag <= 1'b1;
         conflict_cnt  <= (conflict_cnt == CNT_MAX) ? CNT_MAX : conflict_cnt + CNT_ONE;
      end else begin
         conflict_flag <= conflict_flag;
         conflict_cnt  <= conflict_cnt;
      end
   end

`ifdef BUS_MUX_PARITY_EN
   // Parity follows bus_out exactly, updating only on a load.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         bus_parity <= 1'b0;
      end else if (mode_s == MODE_LOAD) begin
         bus_parity <= even_parity(word_s);
      end else begin
         bus_parity <= bus_parity;
      end
   end
`else
   assign bus_parity = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed self-checking bench for bus_mux_reg with hand-computed expectations.
module tb_bus_mux_reg;
   localparam int W = 32;
   localparam int N = 24;
   localparam int S = 5;
   localparam int C = 8;

   logic             clock = 1'b0;
   logic             clear = 1'b0;
   logic [N*W-1:0]   src_data = '0;
   logic [N-1:0]     src_en = '0;
   logic             hold = 1'b0;
   logic             clr_err = 1'b0;
   logic [W-1:0]     bus_out;
   logic [S-1:0]     sel_out;
   logic             bus_valid;
   logic             conflict_flag;
   logic [C-1:0]     conflict_cnt;
   logic             bus_parity;

   int total = 0;
   int bad = 0;

   bus_mux_reg #(.WIDTH(W), .NSRC(N), .SELW(S), .CNTW(C)) dut (
      .clock(clock), .clear(clear), .src_data(src_data), .src_en(src_en),
      .hold(hold), .clr_err(clr_err), .bus_out(bus_out), .sel_out(sel_out),
      .bus_valid(bus_valid), .conflict_flag(conflict_flag),
      .conflict_cnt(conflict_cnt), .bus_parity(bus_parity)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic exp_par(input logic [31:0] w);
`ifdef BUS_MUX_PARITY_EN
      return ^w;
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_word(input int idx, input logic [31:0] val);
      src_data[idx*W +: W] = val;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_bus(input string tag, input logic [31:0] w, input int sel, input logic v);
      check_eq({tag, ".bus"}, bus_out, w);
      check_eq({tag, ".sel"}, 32'(sel_out), 32'(sel));
      check_eq({tag, ".valid"}, 32'(bus_valid), 32'(v));
      check_eq({tag, ".par"}, 32'(bus_parity), 32'(exp_par(w)));
   endtask

   task automatic check_err(input string tag, input logic f, input int cnt);
      check_eq({tag, ".flag"}, 32'(conflict_flag), 32'(f));
      check_eq({tag, ".cnt"}, 32'(conflict_cnt), 32'(cnt));
   endtask

   initial begin
      #1 clear = 1'b1;
      #1;
      check_bus("reset", 32'h0, 0, 1'b0);
      check_err("reset", 1'b0, 0);

      // Load then asynchronous reset between edges
      clear = 1'b0;
      set_word(5, 32'hDEADBEEF);
      src_en = 24'(1) << 5;
      tick();
      check_bus("load5", 32'hDEADBEEF, 5, 1'b1);
      #2 clear = 1'b1;
      #1;
      check_bus("midrst", 32'h0, 0, 1'b0);
      check_err("midrst", 1'b0, 0);
      clear = 1'b0;

      // Single load
      set_word(21, 32'h12345678);
      src_en = 24'(1) << 21;
      tick();
      check_bus("load21", 32'h12345678, 21, 1'b1);
      check_err("load21", 1'b0, 0);

      // Keep for three cycles
      src_en = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_bus($sformatf("keep%0d", k), 32'h12345678, 21, 1'b0);
      end

      // Hold with a new enable present
      set_word(2, 32'h0BADF00D);
      hold = 1'b1;
      src_en = 24'(1) << 2;
      tick();
      check_bus("hold", 32'h12345678, 21, 1'b0);

      // Load source 2, then hold keeps valid high
      hold = 1'b0;
      tick();
      check_bus("load2", 32'h0BADF00D, 2, 1'b1);
      hold = 1'b1;
      src_en = '0;
      tick();
      check_bus("holdv", 32'h0BADF00D, 2, 1'b1);
      hold = 1'b0;

      // Source 0 boundary
      set_word(0, 32'hCAFE0001);
      src_en = 24'h000001;
      tick();
      check_bus("load0", 32'hCAFE0001, 0, 1'b1);
      check_err("load0", 1'b0, 0);

      // Conflict: lowest index wins
      set_word(3, 32'hA5A5A5A5);
      set_word(7, 32'h5A5A5A5A);
      src_en = (24'(1) << 3) | (24'(1) << 7);
      tick();
      check_bus("conf", 32'hA5A5A5A5, 3, 1'b1);
      check_err("conf", 1'b1, 1);

      // Conflict under hold still counts
      hold = 1'b1;
      src_en = (24'(1) << 4) | (24'(1) << 9);
      tick();
      check_bus("confhold", 32'hA5A5A5A5, 3, 1'b1);
      check_err("confhold", 1'b1, 2);
      hold = 1'b0;

      // Top two sources in conflict; saturate the counter
      set_word(22, 32'h00C0FFEE);
      set_word(23, 32'hFFFFFFFF);
      src_en = (24'(1) << 22) | (24'(1) << 23);
      for (int k = 2; k <= 300; k++) begin
         tick();
         if (k == 2) check_bus("conftop", 32'h00C0FFEE, 22, 1'b1);
         if (k == 253) check_err("cnt254", 1'b1, 254);
      end
      check_err("sat", 1'b1, 255);

      // clr_err beats a simultaneous conflict
      clr_err = 1'b1;
      tick();
      check_err("clrconf", 1'b0, 0);
      check_bus("clrconf", 32'h00C0FFEE, 22, 1'b1);
      clr_err = 1'b0;

      // Parity loads, single source so no new conflict
      set_word(10, 32'h00000007);
      src_en = 24'(1) << 10;
      tick();
      check_bus("par7", 32'h00000007, 10, 1'b1);
      check_err("par7", 1'b0, 0);
      set_word(11, 32'h00000003);
      src_en = 24'(1) << 11;
      tick();
      check_bus("par3", 32'h00000003, 11, 1'b1);
      src_en = '0;
      tick();
      check_bus("parkeep", 32'h00000003, 11, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NSRC source words using a one-hot drive-enable vector and a built-in priority encoder, then registers the result onto the shared bus.
- Adds a bus-keeper hold, multi-driver conflict detection with a sticky flag and a saturating count, and a registered select/valid report.
- Sits between the register file, special registers and memory data path on one side, and all bus consumers on the other.

Parameters:
- WIDTH, 32: bus and source word width in bits.
- NSRC, 24: number of bus sources; must be 2..32.
- SELW, 5: encoded select width; must satisfy 2**SELW >= NSRC.
- CNTW, 8: width of the conflict counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- src_data  in  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_en  in  NSRC  per-source drive enables, intended one-hot.
- hold  in  1  freezes the bus register and select report for the cycle.
- clr_err  in  1  synchronous clear of conflict_flag and conflict_cnt.
- bus_out  out  WIDTH  registered bus value.
- sel_out  out  SELW  registered encoded index of the source that drove bus_out.
- bus_valid  out  1  high when bus_out was loaded from a source in the previous cycle.
- conflict_flag  out  1  sticky flag: more than one enable has been seen asserted.
- conflict_cnt  out  CNTW  saturating count of conflict cycles.
- bus_parity  out  1  even parity of bus_out (see Optional Feature).

Behaviour:
- Reset (clear=1, asynchronous): bus_out=0, sel_out=0, bus_valid=0, conflict_flag=0, conflict_cnt=0, bus_parity=0. Reset overrides every other input, including in the middle of any operation.
- Encoder (combinational): sel is the lowest index i with src_en[i]=1. any_en is the OR of src_en. multi is 1 when two or more bits of src_en are set.
- Latency: exactly one cycle. A source word presented with its enable in cycle N appears on bus_out and sel_out after edge N+1.
- Load (hold=0, any_en=1): bus_out <= word[sel]; sel_out <= sel; bus_valid <= 1.
- Keep (hold=0, any_en=0): bus_out and sel_out retain their values; bus_valid <= 0. The bus never goes X.
- Hold (hold=1): bus_out, sel_out and bus_valid all retain their values, regardless of src_en.
- Conflict (multi=1, evaluated regardless of hold): the lowest index still wins the load; conflict_flag <= 1; conflict_cnt increments by 1, saturating at 2**CNTW-1 with no wrap.
- clr_err=1: conflict_flag <= 0 and conflict_cnt <= 0. If multi=1 in the same cycle, clr_err wins: the result is flag=0 and cnt=0.
- Source indices >= NSRC do not exist; bits of a select above NSRC-1 can never be produced.
- No internal FSM beyond the Load/Keep/Hold register modes; all mode decisions are per-cycle and combinational from hold and src_en.

Optional Feature:
- Macro: BUS_MUX_PARITY_EN.
- Defined: bus_parity is a register updated together with bus_out, holding the XOR-reduce of the loaded word. It keeps its value under Keep and Hold, and resets to 0.
- Not defined: bus_parity is tied to 0 and no parity logic is synthesised. The port list is identical in both builds.

Test Plan:
- Reset mid-load: src_en=1<<5 with word5=32'hDEADBEEF, then assert clear asynchronously between edges -> all outputs read 0 immediately, with no wait for a clock edge.
- Single load: src_en=1<<21 with word21=32'h12345678 -> after 1 edge, bus_out=32'h12345678, sel_out=21, bus_valid=1, conflict_flag=0.
- Keep/hold: after the previous load, apply src_en=0 for 3 cycles, then hold=1 with src_en=1<<2 -> bus_out stays 32'h12345678 and sel_out stays 21 throughout; bus_valid=0.
- Conflict: src_en=(1<<3)|(1<<7) with word3=32'hA5A5A5A5 -> bus_out=32'hA5A5A5A5, sel_out=3, conflict_flag=1, conflict_cnt=1. Then 300 further conflict cycles -> conflict_cnt=255 (saturated).
- clr_err against conflict: assert clr_err and a conflict in the same cycle -> conflict_flag=0, conflict_cnt=0 on the next cycle.
- Parity (BUS_MUX_PARITY_EN defined): load 32'h00000007 -> bus_parity=1; load 32'h00000003 -> bus_parity=0. With the macro undefined, bus_parity is always 0.
